// File: rtl/rr_mux_arb_if.sv
// Handshake bundle for rr_mux_arb: NUM_SRC request/grant channels on the
// producer side and a single valid/ready word channel on the sink side.
interface rr_mux_arb_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
);
    logic                     mode;
    logic [NUM_SRC-1:0]       src_valid;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic [SEL_W-1:0]         out_sel;
    logic                     out_ready;

    modport master (
        output mode, src_valid, src_data, out_ready,
        input  src_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  mode, src_valid, src_data, out_ready,
        output src_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_mux_arb.sv
// N-way arbitrated selector. One source wins per cycle (round-robin or fixed
// priority) and its word is loaded into a single output pipe register.
module rr_mux_arb #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input logic         clk,
    input logic         rst_n,
    rr_mux_arb_if.slave bus
);
    logic [SEL_W-1:0]   rrPtr;
    logic [SEL_W-1:0]   grantIdx;
    logic [NUM_SRC-1:0] grantOneHot;
    logic               anyValid;
    logic               accept;
    logic               xfer;

    // Pointer advances to the source just after the winner, wrapping to 0.
    function automatic logic [SEL_W-1:0] nextPtr(input logic [SEL_W-1:0] g);
        if (g == SEL_W'(NUM_SRC - 1)) return '0;
        return g + SEL_W'(1);
    endfunction

    assign anyValid = |bus.src_valid;
    // Output register can take a new word when empty or when its word leaves now.
    assign accept   = !bus.out_valid || bus.out_ready;
    assign xfer     = accept && anyValid;

    // Winner search: fixed priority scans from 0, round-robin scans from rrPtr with wrap.
    always_comb begin
        logic found;
        int   cand;
        grantIdx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.mode) cand = k;
            else          cand = (int'(rrPtr) + k) % NUM_SRC;
            if (!found && bus.src_valid[cand]) begin
                grantIdx = cand[SEL_W-1:0];
                found    = 1'b1;
            end
        end
    end

    // One-hot grant, suppressed while reset is asserted or when nothing can move.
    always_comb begin
        grantOneHot = '0;
        if (rst_n && xfer) grantOneHot[grantIdx] = 1'b1;
    end

    assign bus.src_ready = grantOneHot;

    // Output pipe register and round-robin pointer; both change only on a transfer or drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            rrPtr         <= '0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.src_data[grantIdx*WIDTH +: WIDTH];
            bus.out_sel   <= grantIdx;
            rrPtr         <= nextPtr(grantIdx);
        end else if (accept) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
